// File: rtl/prim_clock_gate_ctrl_if.sv
// Handshake bundle between power-management control and the clock-gate controller.
// The controller takes the slave view; the requester side takes the master view.
interface prim_clock_gate_ctrl_if #(
    parameter int NumChan = 4
) ();
    logic [NumChan-1:0] req_en_i;
    logic [NumChan-1:0] idle_i;
    logic               test_en_i;
    logic [NumChan-1:0] en_o;
    logic [NumChan-1:0] ack_o;
    logic               all_off_o;

    modport master (
        output req_en_i, idle_i, test_en_i,
        input  en_o, ack_o, all_off_o
    );

    modport slave (
        input  req_en_i, idle_i, test_en_i,
        output en_o, ack_o, all_off_o
    );
endinterface

// File: rtl/prim_clock_gate_ctrl.sv
// Multi-channel clock-enable controller: synchronised request, idle hold-off before
// gating, and a settle delay before acknowledging a wake.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  ON    | enable high, acknowledged; waiting for the request to drop
//  DRAIN | enable still high; counting consecutive consumer-idle cycles
//  OFF   | enable low (except test force); waiting for a request
//  WAKE  | enable high, settling for WakeCycles before acknowledging
module prim_clock_gate_ctrl #(
    parameter int   NumChan    = 4,
    parameter int   SyncStages = 2,
    parameter int   IdleCycles = 8,
    parameter int   WakeCycles = 2,
    parameter logic ResetOn    = 1'b1
) (
    input logic                  clk_i,
    input logic                  rst_i,
    prim_clock_gate_ctrl_if.slave bus
);

    localparam int MaxCycles = (IdleCycles > WakeCycles) ? IdleCycles : WakeCycles;
    localparam int CntW      = $clog2(MaxCycles) + 1;

    localparam logic [CntW-1:0] IdleLast = CntW'(IdleCycles - 1);
    localparam logic [CntW-1:0] WakeLast = CntW'(WakeCycles - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    localparam logic [1:0] ST_ON    = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_OFF   = 2'd2;
    localparam logic [1:0] ST_WAKE  = 2'd3;
    localparam logic [1:0] ST_RESET = ResetOn ? ST_ON : ST_OFF;

    logic [NumChan-1:0] en_vec;
    logic [NumChan-1:0] ack_vec;
    logic [NumChan-1:0] off_next;
    logic               all_off_q;

    for (genvar i = 0; i < NumChan; i++) begin : g_chan
        logic [SyncStages-1:0] sync_q;
        logic                  req_s;
        logic [1:0]            state_q, state_d;
        logic [CntW-1:0]       cnt_q, cnt_d;
        logic                  en_q, ack_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                sync_q <= {SyncStages{ResetOn}};
            end else begin
                sync_q <= {sync_q[SyncStages-2:0], bus.req_en_i[i]};
            end
        end

        assign req_s = sync_q[SyncStages-1];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_ON: begin
                    if (!req_s) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end
                end
                ST_DRAIN: begin
                    // A returning request wins over everything, so enable never dips.
                    if (req_s) begin
                        state_d = ST_ON;
                    end else if (!bus.idle_i[i]) begin
                        cnt_d = '0;
                    end else if (cnt_q == IdleLast) begin
                        state_d = ST_OFF;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                ST_OFF: begin
                    if (req_s) begin
                        state_d = ST_WAKE;
                        cnt_d   = '0;
                    end
                end
                ST_WAKE: begin
                    if (cnt_q == WakeLast) begin
                        state_d = ST_ON;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: state_d = ST_RESET;
            endcase
        end

        // Enable and acknowledge come straight from flops loaded with the next-state decode.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= ST_RESET;
                cnt_q   <= '0;
                en_q    <= ResetOn;
                ack_q   <= ResetOn;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                en_q    <= (state_d != ST_OFF);
                ack_q   <= (state_d == ST_ON);
            end
        end

        assign en_vec[i]   = en_q;
        assign ack_vec[i]  = ack_q;
        assign off_next[i] = (state_d == ST_OFF);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            all_off_q <= ~ResetOn;
        end else begin
            all_off_q <= &off_next;
        end
    end

    assign bus.en_o      = en_vec | {NumChan{bus.test_en_i}};
    assign bus.ack_o     = ack_vec;
    assign bus.all_off_o = all_off_q;

endmodule

// File: tb/tb_prim_clock_gate_ctrl.sv
// Bench for prim_clock_gate_ctrl: directed timing scenarios then random traffic,
// every edge compared against a cycle-count model of each channel.
module tb_prim_clock_gate_ctrl;
    localparam int   NumChan    = 4;
    localparam int   SyncStages = 2;
    localparam int   IdleCycles = 8;
    localparam int   WakeCycles = 2;
    localparam logic ResetOn    = 1'b1;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    prim_clock_gate_ctrl_if #(.NumChan(NumChan)) bus ();

    prim_clock_gate_ctrl #(
        .NumChan(NumChan), .SyncStages(SyncStages), .IdleCycles(IdleCycles),
        .WakeCycles(WakeCycles), .ResetOn(ResetOn)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    logic [NumChan-1:0] req_v, idle_v;
    logic               test_v;
    logic [NumChan-1:0] en_acc;

    // Model: request history queue plus per-channel flags and cycle tallies.
    logic [NumChan-1:0] req_hist[$];
    logic [NumChan-1:0] m_en, m_ack, m_drain;
    int                 m_streak[NumChan];
    int                 m_wake[NumChan];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        req_hist.delete();
        for (int s = 0; s < SyncStages; s++) req_hist.push_back({NumChan{ResetOn}});
        m_en    = {NumChan{ResetOn}};
        m_ack   = {NumChan{ResetOn}};
        m_drain = '0;
        for (int c = 0; c < NumChan; c++) begin
            m_streak[c] = 0;
            m_wake[c]   = 0;
        end
    endtask

    task automatic mdl_step();
        logic [NumChan-1:0] rs;
        rs = req_hist.pop_front();
        req_hist.push_back(req_v);
        for (int c = 0; c < NumChan; c++) begin
            if (m_ack[c]) begin
                if (!rs[c]) begin
                    m_ack[c] = 1'b0; m_drain[c] = 1'b1; m_streak[c] = 0;
                end
            end else if (m_drain[c]) begin
                if (rs[c]) begin
                    m_ack[c] = 1'b1; m_drain[c] = 1'b0;
                end else if (idle_v[c]) begin
                    m_streak[c]++;
                    if (m_streak[c] == IdleCycles) begin
                        m_en[c] = 1'b0; m_drain[c] = 1'b0;
                    end
                end else begin
                    m_streak[c] = 0;
                end
            end else if (!m_en[c]) begin
                if (rs[c]) begin
                    m_en[c] = 1'b1; m_wake[c] = 0;
                end
            end else begin
                m_wake[c]++;
                if (m_wake[c] == WakeCycles) m_ack[c] = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        bus.req_en_i  = req_v;
        bus.idle_i    = idle_v;
        bus.test_en_i = test_v;
        @(posedge clk_i);
        mdl_step();
        #1;
        chk("en", 32'(bus.en_o), 32'(m_en | {NumChan{test_v}}));
        chk("ack", 32'(bus.ack_o), 32'(m_ack));
        chk("all_off", 32'(bus.all_off_o), 32'(m_en == '0));
        en_acc = en_acc & bus.en_o;
    endtask

    function automatic logic pick(input int sel, input int ch);
        case (sel)
            0:       return bus.en_o[ch];
            1:       return bus.ack_o[ch];
            default: return bus.all_off_o;
        endcase
    endfunction

    task automatic edges_until(input int sel, input int ch, input logic val, output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (pick(sel, ch) == val) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n, n2;
        req_v  = '1;
        idle_v = '1;
        test_v = 1'b0;
        en_acc = '1;
        bus.req_en_i  = req_v;
        bus.idle_i    = idle_v;
        bus.test_en_i = 1'b0;
        rst_i = 1'b1;
        mdl_reset();
        #3;
        chk("rst_en", 32'(bus.en_o), 32'hF);
        chk("rst_ack", 32'(bus.ack_o), 32'hF);
        chk("rst_all_off", 32'(bus.all_off_o), 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        step();
        chk("rel_en", 32'(bus.en_o), 32'hF);
        chk("rel_ack", 32'(bus.ack_o), 32'hF);

        // Gate channel 0.
        req_v = 4'hE;
        edges_until(1, 0, 1'b0, n);
        chk("gate_ack_fall", 32'(n), 32'd3);
        edges_until(0, 0, 1'b0, n2);
        chk("gate_en_fall", 32'(n + n2), 32'd11);
        chk("gate_others_en", 32'(bus.en_o[3:1]), 32'h7);
        chk("gate_others_ack", 32'(bus.ack_o[3:1]), 32'h7);

        // Idle interruption on channel 0.
        req_v = 4'hF;
        repeat (8) step();
        req_v = 4'hE;
        repeat (3) step();
        chk("drain_ack", 32'(bus.ack_o[0]), 32'h0);
        repeat (5) step();
        idle_v = 4'hE;
        step();
        idle_v = 4'hF;
        edges_until(0, 0, 1'b0, n);
        chk("idle_restart", 32'(n), 32'd8);

        // Wake channel 1 from OFF.
        req_v = 4'hC;
        repeat (12) step();
        req_v[1] = 1'b1;
        edges_until(0, 1, 1'b1, n);
        chk("wake_en_rise", 32'(n), 32'd3);
        edges_until(1, 1, 1'b1, n);
        chk("wake_ack_rise", 32'(n), 32'd2);

        // Drop the request mid-wake: the wake still completes.
        req_v[1] = 1'b0;
        repeat (12) step();
        req_v[1] = 1'b1;
        edges_until(0, 1, 1'b1, n);
        chk("wake2_en_rise", 32'(n), 32'd3);
        req_v[1] = 1'b0;
        edges_until(1, 1, 1'b1, n);
        chk("wake2_ack_rise", 32'(n), 32'd2);
        edges_until(1, 1, 1'b0, n);
        chk("wake2_ack_fall", 32'(n), 32'd1);

        // Cancel a drain on channel 2.
        en_acc = '1;
        req_v[2] = 1'b0;
        edges_until(1, 2, 1'b0, n);
        chk("cancel_ack_fall", 32'(n), 32'd3);
        repeat (2) step();
        req_v[2] = 1'b1;
        edges_until(1, 2, 1'b1, n);
        chk("cancel_ack_back", 32'(n), 32'd3);
        chk("cancel_no_glitch", 32'(en_acc[2]), 32'h1);

        // Everything off together.
        req_v = '1;
        repeat (12) step();
        chk("all_on_ack", 32'(bus.ack_o), 32'hF);
        req_v = '0;
        edges_until(2, 0, 1'b1, n);
        chk("all_off_edge", 32'(n), 32'd11);

        // Test force is combinational and leaves the FSM alone.
        @(negedge clk_i);
        test_v = 1'b1;
        bus.test_en_i = 1'b1;
        #1;
        chk("test_en", 32'(bus.en_o), 32'hF);
        chk("test_ack", 32'(bus.ack_o), 32'h0);
        step();
        chk("test_all_off", 32'(bus.all_off_o), 32'h1);
        test_v = 1'b0;
        step();

        // Asynchronous reset mid-wake.
        req_v = 4'h2;
        edges_until(0, 1, 1'b1, n);
        chk("rstwake_en_rise", 32'(n), 32'd3);
        @(negedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        chk("arst_en", 32'(bus.en_o), 32'hF);
        chk("arst_ack", 32'(bus.ack_o), 32'hF);
        chk("arst_all_off", 32'(bus.all_off_o), 32'h0);
        mdl_reset();
        req_v = '1;
        bus.req_en_i = req_v;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Random traffic.
        for (int t = 0; t < 1500; t++) begin
            for (int c = 0; c < NumChan; c++) begin
                if ($urandom_range(0, 15) == 0) req_v[c] = ~req_v[c];
                idle_v[c] = ($urandom_range(0, 7) != 0);
            end
            test_v = ($urandom_range(0, 31) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
